muldiv_unit: RTL and testbench

- Iterative multiply/divide unit in the Execute stage. It owns the HI/LO architectural registers for MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- It raises `busy` to the pipeline hazard logic, which stalls F/D on an MFHI/MFLO or a new muldiv op while `busy` is high.
- Operands arrive already forwarded (post ForwardAE/ForwardBE muxes). `hi`/`lo` feed the Execute result mux for MFHI/MFLO.

---
 rtl/muldiv_unit.sv | 185 ++++++++++++++++++
 tb/tb_muldiv_unit.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit that owns HI/LO for MULT(U), DIV(U), MTHI and MTLO.
// Optional MULDIV_FAST_MUL_EN: MULT/MULTU finish in one cycle on a single-cycle multiplier.
module muldiv_unit #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CNT_W = 5
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] srcA,
   input  logic [WIDTH-1:0] srcB,
   input  logic             abort,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy,
   output logic             done
);

   localparam int unsigned PW = 2 * WIDTH;

   localparam logic [2:0] OP_MULT  = 3'd0;
   localparam logic [2:0] OP_MULTU = 3'd1;
   localparam logic [2:0] OP_DIV   = 3'd2;
   localparam logic [2:0] OP_DIVU  = 3'd3;
   localparam logic [2:0] OP_MTHI  = 3'd4;
   localparam logic [2:0] OP_MTLO  = 3'd5;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ITER = 2'd1,
      S_FIX  = 2'd2
   } state_t;

   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [WIDTH-1:0] r_wa;     // product high half / partial remainder
   logic [WIDTH-1:0] r_wb;     // product low half + multiplier / dividend + quotient
   logic [WIDTH-1:0] r_b;      // multiplicand / divisor magnitude
   logic             r_is_div;
   logic             r_neg_q;
   logic             r_neg_r;
   logic             r_dz;

   // Operand magnitudes and result signs for the op being issued
   logic             w_signed_op;
   logic             w_a_neg;
   logic             w_b_neg;
   logic [WIDTH-1:0] w_abs_a;
   logic [WIDTH-1:0] w_abs_b;
   logic             w_req;
   logic             w_issue;

   assign w_signed_op = (op == OP_MULT) || (op == OP_DIV);
   assign w_a_neg     = w_signed_op & srcA[WIDTH-1];
   assign w_b_neg     = w_signed_op & srcB[WIDTH-1];
   assign w_abs_a     = w_a_neg ? (~srcA + WIDTH'(1)) : srcA;
   assign w_abs_b     = w_b_neg ? (~srcB + WIDTH'(1)) : srcB;
   assign w_req       = start && !abort && (r_state == S_IDLE);

`ifdef MULDIV_FAST_MUL_EN
   logic          w_fast;
   logic [PW-1:0] w_ax;
   logic [PW-1:0] w_bx;
   logic [PW-1:0] w_fast_prod;

   assign w_fast      = w_req && ((op == OP_MULT) || (op == OP_MULTU));
   assign w_ax        = (op == OP_MULT) ? {{WIDTH{srcA[WIDTH-1]}}, srcA} : {WIDTH'(0), srcA};
   assign w_bx        = (op == OP_MULT) ? {{WIDTH{srcB[WIDTH-1]}}, srcB} : {WIDTH'(0), srcB};
   assign w_fast_prod = PW'(w_ax * w_bx);
   assign w_issue     = w_req && ((op == OP_DIV) || (op == OP_DIVU));
`else
   assign w_issue     = w_req && (op[2] == 1'b0);
`endif

   // One shift-add multiply step
   logic [WIDTH:0]   w_madd;
   logic [PW-1:0]    w_mul_next;
   assign w_madd     = {1'b0, r_wa} + (r_wb[0] ? {1'b0, r_b} : {1'b0, WIDTH'(0)});
   assign w_mul_next = {w_madd, r_wb[WIDTH-1:1]};

   // One restoring divide step; bit WIDTH of the trial is its sign
   logic [WIDTH:0]   w_shift;
   logic [WIDTH:0]   w_trial;
   logic             w_q_bit;
   logic [WIDTH-1:0] w_rem_next;
   assign w_shift    = {r_wa, r_wb[WIDTH-1]};
   assign w_trial    = w_shift - {1'b0, r_b};
   assign w_q_bit    = ~w_trial[WIDTH];
   assign w_rem_next = w_q_bit ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0];

   // Sign fix-up applied while in FIX
   logic [PW-1:0]    w_prod;
   logic [PW-1:0]    w_prod_fix;
   logic [WIDTH-1:0] w_quo_fix;
   logic [WIDTH-1:0] w_rem_fix;
   assign w_prod     = {r_wa, r_wb};
   assign w_prod_fix = r_neg_q ? (~w_prod + PW'(1)) : w_prod;
   assign w_quo_fix  = r_dz ? {WIDTH{1'b1}} : (r_neg_q ? (~r_wb + WIDTH'(1)) : r_wb);
   assign w_rem_fix  = r_neg_r ? (~r_wa + WIDTH'(1)) : r_wa;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state  <= S_IDLE;
         r_cnt    <= '0;
         r_wa     <= '0;
         r_wb     <= '0;
         r_b      <= '0;
         r_is_div <= 1'b0;
         r_neg_q  <= 1'b0;
         r_neg_r  <= 1'b0;
         r_dz     <= 1'b0;
         hi       <= '0;
         lo       <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_issue) begin
                  r_state  <= S_ITER;
                  busy     <= 1'b1;
                  r_cnt    <= '0;
                  r_wa     <= '0;
                  r_wb     <= w_abs_a;
                  r_b      <= w_abs_b;
                  r_is_div <= op[1];
                  r_neg_q  <= w_a_neg ^ w_b_neg;
                  r_neg_r  <= w_a_neg;
                  r_dz     <= op[1] && (srcB == '0);
               end else if (w_req && (op == OP_MTHI)) begin
                  hi <= srcA;
               end else if (w_req && (op == OP_MTLO)) begin
                  lo <= srcA;
               end
`ifdef MULDIV_FAST_MUL_EN
               if (w_fast) begin
                  hi   <= w_fast_prod[PW-1:WIDTH];
                  lo   <= w_fast_prod[WIDTH-1:0];
                  done <= 1'b1;
               end
`endif
            end
            S_ITER: begin
               if (abort) begin
                  r_state <= S_IDLE;
                  busy    <= 1'b0;
               end else begin
                  if (r_is_div) begin
                     r_wa <= w_rem_next;
                     r_wb <= {r_wb[WIDTH-2:0], w_q_bit};
                  end else begin
                     r_wa <= w_mul_next[PW-1:WIDTH];
                     r_wb <= w_mul_next[WIDTH-1:0];
                  end
                  r_cnt <= r_cnt + CNT_W'(1);
                  if (r_cnt == CNT_W'(WIDTH - 1)) begin
                     r_state <= S_FIX;
                  end
               end
            end
            S_FIX: begin
               r_state <= S_IDLE;
               busy    <= 1'b0;
               if (!abort) begin
                  if (r_is_div) begin
                     hi <= w_rem_fix;
                     lo <= w_quo_fix;
                  end else begin
                     hi <= w_prod_fix[PW-1:WIDTH];
                     lo <= w_prod_fix[WIDTH-1:0];
                  end
                  done <= 1'b1;
               end
            end
            default: begin
               r_state <= S_IDLE;
               busy    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: arithmetic reference model with per-cycle compare plus directed literal checks.
module tb_muldiv_unit;

   localparam int unsigned W = 32;
`ifdef MULDIV_FAST_MUL_EN
   localparam int MUL_BUSY = 0;
`else
   localparam int MUL_BUSY = 33;
`endif

   logic         clk;
   logic         reset_n;
   logic         start;
   logic [2:0]   op;
   logic [W-1:0] srcA;
   logic [W-1:0] srcB;
   logic         abort;
   logic [W-1:0] hi;
   logic [W-1:0] lo;
   logic         busy;
   logic         done;

   int n_checks = 0;
   int n_errors = 0;
   bit chk_en   = 0;

   muldiv_unit dut (
      .clk     (clk),
      .reset_n (reset_n),
      .start   (start),
      .op      (op),
      .srcA    (srcA),
      .srcB    (srcB),
      .abort   (abort),
      .hi      (hi),
      .lo      (lo),
      .busy    (busy),
      .done    (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference results from plain arithmetic, returned as {hi, lo}
   function automatic logic [63:0] mul_ref(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb;
      longint unsigned ua, ub;
      if (o == 3'd0) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
         return 64'(sa * sb);
      end
      ua = {32'd0, a};
      ub = {32'd0, b};
      return ua * ub;
   endfunction

   function automatic logic [63:0] div_ref(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, q, r;
      logic [31:0] uq, ur;
      if (b == 32'd0) return {a, 32'hFFFF_FFFF};
      if (o == 3'd2) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
         q  = sa / sb;
         r  = sa % sb;
         return {r[31:0], q[31:0]};
      end
      uq = a / b;
      ur = a % b;
      return {ur, uq};
   endfunction

   // Transaction-level model: a mul/div lands 33 edges after issue unless aborted
   logic [W-1:0] m_hi, m_lo, p_hi, p_lo;
   logic         m_busy, m_done;
   int           m_left;

   always @(posedge clk or negedge reset_n) begin
      logic [63:0] res;
      if (!reset_n) begin
         m_hi <= '0; m_lo <= '0; p_hi <= '0; p_lo <= '0;
         m_busy <= 1'b0; m_done <= 1'b0; m_left <= 0;
      end else begin
         m_done <= 1'b0;
         if (!m_busy) begin
            if (start && !abort) begin
               if (op == 3'd0 || op == 3'd1) begin
                  res = mul_ref(op, srcA, srcB);
`ifdef MULDIV_FAST_MUL_EN
                  m_hi <= res[63:32]; m_lo <= res[31:0]; m_done <= 1'b1;
`else
                  p_hi <= res[63:32]; p_lo <= res[31:0]; m_busy <= 1'b1; m_left <= 33;
`endif
               end else if (op == 3'd2 || op == 3'd3) begin
                  res = div_ref(op, srcA, srcB);
                  p_hi <= res[63:32]; p_lo <= res[31:0]; m_busy <= 1'b1; m_left <= 33;
               end else if (op == 3'd4) begin
                  m_hi <= srcA;
               end else if (op == 3'd5) begin
                  m_lo <= srcA;
               end
            end
         end else if (abort) begin
            m_busy <= 1'b0;
         end else if (m_left == 1) begin
            m_hi <= p_hi; m_lo <= p_lo; m_done <= 1'b1; m_busy <= 1'b0;
         end else begin
            m_left <= m_left - 1;
         end
      end
   end

   // Every-cycle compare against the model
   always @(negedge clk) begin
      if (chk_en) begin
         check("cyc hi", hi, m_hi);
         check("cyc lo", lo, m_lo);
         check("cyc busy", 32'(busy), 32'(m_busy));
         check("cyc done", 32'(done), 32'(m_done));
      end
   end

   task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                         input int exp_busy, input string name);
      int nb;
      bit seen;
      nb = 0;
      seen = 0;
      @(negedge clk);
      start = 1'b1; op = o; srcA = a; srcB = b;
      @(posedge clk);
      #1 start = 1'b0;
      for (int i = 0; i < 60 && !seen; i++) begin
         @(negedge clk);
         if (done) seen = 1;
         else if (busy) nb++;
      end
      check({name, " done seen"}, 32'(seen), 32'd1);
      check({name, " busy cycles"}, 32'(nb), 32'(exp_busy));
      check({name, " hi"}, hi, exp_hi);
      check({name, " lo"}, lo, exp_lo);
      @(negedge clk);
      check({name, " done single pulse"}, 32'(done), 32'd0);
   endtask

   task automatic issue_move(input logic [2:0] o, input logic [31:0] a);
      @(negedge clk);
      start = 1'b1; op = o; srcA = a; srcB = '0;
      @(posedge clk);
      #1 start = 1'b0;
      @(negedge clk);
      check("move busy", 32'(busy), 32'd0);
      check("move done", 32'(done), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit seen;
      reset_n = 1'b0; start = 1'b0; op = '0; srcA = '0; srcB = '0; abort = 1'b0;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      chk_en  = 1'b1;
      check("reset hi", hi, 32'h0);
      check("reset lo", lo, 32'h0);
      check("reset busy", 32'(busy), 32'd0);
      check("reset done", 32'(done), 32'd0);

      run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, MUL_BUSY, "multu max");
      run_op(3'd0, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, MUL_BUSY, "mult -3x7");
      run_op(3'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33, "div -7/2");
      run_op(3'd3, 32'd7, 32'd0, 32'h0000_0007, 32'hFFFF_FFFF, 33, "divu 7/0");
      run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 33, "div ovf");
      run_op(3'd2, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 33, "div -5/0");

      issue_move(3'd4, 32'h1234_5678);
      check("mthi hi", hi, 32'h1234_5678);
      issue_move(3'd5, 32'hCAFE_F00D);
      check("mtlo lo", lo, 32'hCAFE_F00D);
      check("mtlo keeps hi", hi, 32'h1234_5678);

      // Abort and start in the same idle cycle: nothing issues
      @(negedge clk);
      start = 1'b1; abort = 1'b1; op = 3'd1; srcA = 32'd3; srcB = 32'd5;
      @(posedge clk);
      #1 start = 1'b0; abort = 1'b0;
      @(negedge clk);
      check("abort+start busy", 32'(busy), 32'd0);
      check("abort+start done", 32'(done), 32'd0);
      check("abort+start lo", lo, 32'hCAFE_F00D);

      // Abort a divide mid-flight
      @(negedge clk);
      start = 1'b1; op = 3'd3; srcA = 32'd100; srcB = 32'd7;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (10) @(negedge clk);
      check("pre-abort busy", 32'(busy), 32'd1);
      abort = 1'b1;
      @(posedge clk);
      #1 abort = 1'b0;
      @(negedge clk);
      check("abort busy", 32'(busy), 32'd0);
      seen = 0;
      repeat (40) begin
         @(negedge clk);
         if (done) seen = 1;
      end
      check("abort no done", 32'(seen), 32'd0);
      check("abort hi kept", hi, 32'h1234_5678);
      check("abort lo kept", lo, 32'hCAFE_F00D);

      // Starts while busy are ignored
      @(negedge clk);
      start = 1'b1; op = 3'd3; srcA = 32'd100; srcB = 32'd7;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (5) @(negedge clk);
      start = 1'b1; op = 3'd5; srcA = 32'd1;
      @(negedge clk);
      op = 3'd1; srcA = 32'd9; srcB = 32'd9;
      @(negedge clk);
      start = 1'b0;
      check("ignored mtlo lo", lo, 32'hCAFE_F00D);
      seen = 0;
      for (int i = 0; i < 60 && !seen; i++) begin
         @(negedge clk);
         if (done) seen = 1;
      end
      check("divu 100/7 done", 32'(seen), 32'd1);
      check("divu 100/7 lo", lo, 32'd14);
      check("divu 100/7 hi", hi, 32'd2);

      // Asynchronous reset mid-multiply
      @(negedge clk);
      start = 1'b1; op = 3'd1; srcA = 32'hFFFF_FFFF; srcB = 32'h0000_0003;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (20) @(negedge clk);
      @(posedge clk);
      #2 reset_n = 1'b0;
      #1;
      check("async rst hi", hi, 32'h0);
      check("async rst lo", lo, 32'h0);
      check("async rst busy", 32'(busy), 32'd0);
      check("async rst done", 32'(done), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      repeat (3) @(negedge clk);
      check("post rst busy", 32'(busy), 32'd0);

      chk_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
